run_detect_sched: RTL and testbench
===================================

# run_detect_sched

Time-shared scheduler for the serial run detector. It arbitrates N_CH independent bit-stream requesters round-robin onto a single detection datapath. On every grant switch it saves and restores the per-channel detector context, so each channel sees an uninterrupted detector. It sits between the per-channel serial front-ends and the event collector consuming out_valid/out_ch/out_x/out_y.

## Interface
- N_CH, 4: number of requesting channels (2..16).
- BURST, 4: maximum bits accepted per grant before forced rotation (1..15).
- CW, $clog2(N_CH): channel-id width (derived).

- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset: resetn, synchronous, active-low; clock clk.
- req_valid  in  N_CH  per-channel bit valid.
- req_bit  in  N_CH  per-channel data bit.
- req_ready  out  N_CH  per-channel accept; one-hot or zero.
- ch_clear  in  N_CH  per-channel context clear (pulse).
- out_valid  out  1  detection result valid (one per accepted bit).
- out_ch  out  CW  channel of the result.
- out_x  out  1  run length ≥ 2 including this bit.
- out_y  out  1  run length ≥ 3 including this bit.
- busy  out  1  FSM not in IDLE.

## Operation
- Context per channel: vld (1b), last (1b), run (2b, saturating at 3). Working copy: w_vld, w_last, w_run.
- Detection on an accepted bit b: if w_vld and b==w_last, then run'=min(w_run+1,3); otherwise run'=1. Then w_last=b, w_vld=1, out_x=(run'≥2), out_y=(run'≥3).
- FSM states: IDLE, LOAD, RUN, STORE.
  - IDLE: if any req_valid, grant g = lowest index ≥ ptr (cyclic) with req_valid high, then go to LOAD. Otherwise stay.
  - LOAD: copy ctx[g] into the working regs, clear burst count, then go to RUN.
  - RUN: req_ready[g]=1. A bit is accepted when req_valid[g] is high; burst count increments.
    - Go to STORE if req_valid[g] is low in this cycle.
    - Go to STORE if this acceptance makes the count reach BURST.
    - Otherwise stay in RUN.
  - STORE: write the working regs to ctx[g], set ptr=(g+1) mod N_CH, then go to IDLE.
- ch_clear[i]: ctx[i].vld=0 at the next edge.
  - If i==g in LOAD, RUN or STORE, w_vld is also cleared.
  - A bit accepted in the same cycle is evaluated with w_vld=0, so run'=1.
  - In STORE, the clear wins: ctx[g].vld ends at 0.
- req_bit/req_valid of non-granted channels are ignored; requesters must hold the bit until accepted.
- Channels with req_valid low are skipped by arbitration; no starvation: any valid channel is granted within N_CH grants.

## Timing
- Reset values:
  - Outputs: req_ready=0, out_valid=0, out_ch=0, out_x=0, out_y=0, busy=0.
  - Internal: FSM=IDLE, ptr=0, all ctx vld/last/run=0, working regs 0.
- Grant latency: req_valid seen in IDLE at cycle t gives LOAD at t+1; RUN and req_ready high at t+2.
- Result latency: outputs are registered; out_valid/out_ch/out_x/out_y are asserted in the cycle after acceptance, for exactly one cycle.
- Overhead: 3 cycles per grant (IDLE, LOAD, STORE). Peak throughput is BURST bits per BURST+3 cycles.
- req_ready is combinational from state and g only, never from req_valid.
- Reset mid-operation: the next edge returns to reset values; in-flight context is lost and pending results are dropped.

## Test plan
- Reset: hold resetn=0 for 3 cycles with all req_valid=1.
  - Required: all outputs 0, busy=0.
  - After release: req_ready[0] rises 2 cycles later.
- Single channel, N_CH=4, BURST=15: ch0 sends 0,0,0,1,1,1 back-to-back.
  - out_x = 0,1,1,0,1,1; out_y = 0,0,1,0,0,1; out_ch=0 throughout.
- Context preservation, BURST=4: ch0 and ch1 continuously valid; ch0 sends 1×8, ch1 sends 0×8.
  - Grants alternate ch0, ch1, ch0, ch1.
  - The first bit of ch0's second grant yields x=1, y=1 (run carried over, not restarted).
- Valid gap: ch2 sends 1,1, drops req_valid for one cycle, then sends 1.
  - Grant ends with STORE; on re-grant the third bit yields x=1, y=1.
- ch_clear: pulse ch_clear[0] in the same RUN cycle that ch0's third consecutive 0 is accepted.
  - That bit yields x=0, y=0; the next 0 yields x=1, y=0.
- Round-robin fairness and reset mid-RUN: ch1 and ch3 valid, ptr=2.
  - Required grant order: ch3 then ch1.
  - Assert resetn=0 during ch3's RUN: next cycle idle outputs, ptr=0, and ch3's context is invalid afterwards.

Source files
------------

// File: rtl/run_detect_sched_if.sv
// Bus between the per-channel serial front-ends, the run-detect scheduler and the event collector.
interface run_detect_sched_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CW   = $clog2(N_CH)
);
    logic [N_CH-1:0] req_valid;
    logic [N_CH-1:0] req_bit;
    logic [N_CH-1:0] req_ready;
    logic [N_CH-1:0] ch_clear;
    logic            out_valid;
    logic [CW-1:0]   out_ch;
    logic            out_x;
    logic            out_y;
    logic            busy;

    // Front-end / collector side
    modport master (
        output req_valid, req_bit, ch_clear,
        input  req_ready, out_valid, out_ch, out_x, out_y, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_bit, ch_clear,
        output req_ready, out_valid, out_ch, out_x, out_y, busy
    );
endinterface

// File: rtl/run_detect_sched.sv
// Round-robin time-shared run detector: one detection datapath serves N_CH bit streams,
// with per-channel detector context saved on STORE and restored on LOAD.
module run_detect_sched #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned BURST = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    run_detect_sched_if.slave    bus
);
    localparam int unsigned CW = $clog2(N_CH);
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_STORE = 2'd3
    } state_e;

    typedef struct packed {
        logic       vld;
        logic       last;
        logic [1:0] run;
    } ctx_t;

    state_e              state_q, state_d;
    logic [CW-1:0]       g_q, g_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    ctx_t [N_CH-1:0]     ctx_q, ctx_d;
    ctx_t                w_q, w_d;
    logic [BW-1:0]       cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [CW-1:0]       out_ch_q, out_ch_d;
    logic                out_x_q, out_x_d;
    logic                out_y_q, out_y_d;

    logic                grant_found;
    logic [CW-1:0]       grant_idx;
    int unsigned         arb_sum;
    logic [CW-1:0]       arb_cand;
    logic [N_CH-1:0]     ready_c;
    logic                clr_g;
    logic                eff_vld;
    logic [1:0]          run_n;

    // Cyclic priority search: first valid channel at or after ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        arb_sum     = 0;
        arb_cand    = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            arb_sum = 32'(ptr_q) + k;
            if (arb_sum >= N_CH) begin
                arb_sum = arb_sum - N_CH;
            end
            arb_cand = CW'(arb_sum);
            if (!grant_found && bus.req_valid[arb_cand]) begin
                grant_found = 1'b1;
                grant_idx   = arb_cand;
            end
        end
    end

    // Next-state, context save/restore and detection
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        ctx_d       = ctx_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_ch_d    = '0;
        out_x_d     = 1'b0;
        out_y_d     = 1'b0;
        ready_c     = '0;
        clr_g       = bus.ch_clear[g_q];
        eff_vld     = w_q.vld & ~clr_g;
        run_n       = 2'd1;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    g_d     = grant_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                w_d = ctx_q[g_q];
                if (clr_g) begin
                    w_d.vld = 1'b0;
                end
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                ready_c[g_q] = 1'b1;
                if (bus.req_valid[g_q]) begin
                    if (eff_vld && (bus.req_bit[g_q] == w_q.last)) begin
                        run_n = (w_q.run == 2'd3) ? 2'd3 : (w_q.run + 2'd1);
                    end
                    w_d.vld     = 1'b1;
                    w_d.last    = bus.req_bit[g_q];
                    w_d.run     = run_n;
                    out_valid_d = 1'b1;
                    out_ch_d    = g_q;
                    out_x_d     = (run_n >= 2'd2);
                    out_y_d     = (run_n == 2'd3);
                    cnt_d       = cnt_q + BW'(1);
                    if ((cnt_q + BW'(1)) == BW'(BURST)) begin
                        state_d = S_STORE;
                    end
                end else begin
                    if (clr_g) begin
                        w_d.vld = 1'b0;
                    end
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                ctx_d[g_q] = w_q;
                if (clr_g) begin
                    w_d.vld = 1'b0;
                end
                ptr_d   = (g_q == CW'(N_CH - 1)) ? '0 : (g_q + CW'(1));
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A clear always wins over a context write-back in the same cycle
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.ch_clear[i]) begin
                ctx_d[i].vld = 1'b0;
            end
        end
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            ptr_q       <= '0;
            ctx_q       <= '0;
            w_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_x_q     <= 1'b0;
            out_y_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            ctx_q       <= ctx_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_run_detect_sched.sv
// Bench for run_detect_sched: scoreboarded results plus grant-order and corner-case sequences.
module tb_run_detect_sched;
    localparam int unsigned N_CH = 4;
    localparam int unsigned CW   = 2;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    run_detect_sched_if #(.N_CH(N_CH)) if4 ();
    run_detect_sched_if #(.N_CH(N_CH)) if15 ();

    run_detect_sched #(.N_CH(N_CH), .BURST(4)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if4.slave)
    );

    run_detect_sched #(.N_CH(N_CH), .BURST(15)) u_dut15 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if15.slave)
    );

    typedef struct packed {
        logic [CW-1:0] ch;
        logic          x;
        logic          y;
    } res_t;

    typedef struct {
        int   ch;
        logic b;
        logic ex;
        logic ey;
    } vec_t;

    res_t            exp_q[$];
    res_t            exp15_q[$];
    int unsigned     grant_q[$];
    bit              grant_chk = 1'b0;
    logic [N_CH-1:0] prev_rdy  = '0;
    int              errors    = 0;
    int              checks    = 0;
    vec_t            vecs[6];

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard for the BURST=4 instance, plus grant-order tracking
    always @(negedge clk) begin : mon4
        res_t        e;
        int unsigned gi;
        if (if4.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb4_unexpected: got result ch=%0d, required none", if4.out_ch);
            end else begin
                e = exp_q.pop_front();
                chk("sb4_ch", 32'(if4.out_ch), 32'(e.ch));
                chk("sb4_x", 32'(if4.out_x), 32'(e.x));
                chk("sb4_y", 32'(if4.out_y), 32'(e.y));
            end
        end
        if (grant_chk && (if4.req_ready != '0) && (prev_rdy == '0) && (grant_q.size() != 0)) begin
            gi = 99;
            for (int i = 0; i < int'(N_CH); i++) begin
                if (if4.req_ready[i]) gi = i;
            end
            chk("grant_order", gi, grant_q.pop_front());
        end
        prev_rdy = if4.req_ready;
    end

    // Scoreboard for the BURST=15 instance
    always @(negedge clk) begin : mon15
        res_t e;
        if (if15.out_valid === 1'b1) begin
            if (exp15_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb15_unexpected: got result ch=%0d, required none", if15.out_ch);
            end else begin
                e = exp15_q.pop_front();
                chk("sb15_ch", 32'(if15.out_ch), 32'(e.ch));
                chk("sb15_x", 32'(if15.out_x), 32'(e.x));
                chk("sb15_y", 32'(if15.out_y), 32'(e.y));
            end
        end
    end

    // Present one bit on a channel, hold until granted, record the expected result.
    // Called and returns on a falling edge; req_valid is left high.
    task automatic send(input bit s15, input int ch, input logic b,
                        input logic ex, input logic ey, input logic clr);
        int            n = 0;
        logic [CW-1:0] c;
        res_t          e;
        c = CW'(ch);
        if (s15) begin
            if15.req_valid[c] = 1'b1;
            if15.req_bit[c]   = b;
        end else begin
            if4.req_valid[c] = 1'b1;
            if4.req_bit[c]   = b;
        end
        while (!(s15 ? if15.req_ready[c] : if4.req_ready[c])) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout ch%0d: req_ready got 0, required 1", ch);
                return;
            end
        end
        if (clr) if4.ch_clear[c] = 1'b1;
        e.ch = c;
        e.x  = ex;
        e.y  = ey;
        if (s15) exp15_q.push_back(e);
        else     exp_q.push_back(e);
        @(negedge clk);
        if4.ch_clear[c] = 1'b0;
    endtask

    task automatic drop(input int ch);
        logic [CW-1:0] c;
        c = CW'(ch);
        if4.req_valid[c] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (if4.busy !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: busy got 1, required 0");
                return;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{0, 1'b1, 1'b1, 1'b1};

        // Reset held with every channel requesting
        resetn         = 1'b0;
        if4.req_valid  = '1;
        if4.req_bit    = '0;
        if4.ch_clear   = '0;
        if15.req_valid = '0;
        if15.req_bit   = '0;
        if15.ch_clear  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(if4.req_ready), 0);
        chk("rst_out_valid", 32'(if4.out_valid), 0);
        chk("rst_out_ch", 32'(if4.out_ch), 0);
        chk("rst_out_x", 32'(if4.out_x), 0);
        chk("rst_out_y", 32'(if4.out_y), 0);
        chk("rst_busy", 32'(if4.busy), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rel_load_ready", 32'(if4.req_ready), 0);
        chk("rel_load_busy", 32'(if4.busy), 1);
        @(negedge clk);
        chk("rel_ready0_rise", 32'(if4.req_ready), 32'h1);
        if4.req_valid = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Single channel, BURST=15, table of bits with expected flags
        for (int i = 0; i < 6; i++) begin
            send(1'b1, vecs[i].ch, vecs[i].b, vecs[i].ex, vecs[i].ey, 1'b0);
        end
        if15.req_valid = '0;
        repeat (3) @(negedge clk);

        // Context preservation across alternating grants
        grant_q   = {0, 1, 0, 1};
        grant_chk = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(1'b0, 0, 1'b1, logic'(i >= 1), logic'(i >= 2), 1'b0);
                drop(0);
            end
            begin
                for (int i = 0; i < 8; i++) send(1'b0, 1, 1'b0, logic'(i >= 1), logic'(i >= 2), 1'b0);
                drop(1);
            end
        join
        wait_idle();
        chk("alt_grants_left", grant_q.size(), 0);
        grant_chk = 1'b0;

        // Valid gap ends the grant; context carries across
        send(1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        drop(2);
        @(negedge clk);
        chk("gap_store_ready", 32'(if4.req_ready), 0);
        chk("gap_store_busy", 32'(if4.busy), 1);
        send(1'b0, 2, 1'b1, 1'b1, 1'b1, 1'b0);
        drop(2);
        wait_idle();

        // ch_clear coincident with an accepted bit
        send(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        drop(0);
        wait_idle();

        // Give ch3 a stored context, then leave ptr at 2
        send(1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        drop(3);
        wait_idle();
        send(1'b0, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        drop(1);
        wait_idle();

        // Round-robin from ptr=2 picks ch3 over ch1, then reset mid-RUN
        grant_q   = {3};
        grant_chk = 1'b1;
        if4.req_valid[1] = 1'b1;
        if4.req_bit[1]   = 1'b0;
        if4.req_valid[3] = 1'b1;
        if4.req_bit[3]   = 1'b1;
        begin
            int n = 0;
            while (if4.req_ready == '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rr_first_grant", 32'(if4.req_ready), 32'h8);
        begin
            res_t e;
            e.ch = 2'd3;
            e.x  = 1'b1;
            e.y  = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(if4.req_ready), 0);
        chk("midrst_out_valid", 32'(if4.out_valid), 0);
        chk("midrst_out_x", 32'(if4.out_x), 0);
        chk("midrst_busy", 32'(if4.busy), 0);
        resetn  = 1'b1;
        grant_q = {1, 3};
        fork
            begin
                send(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
                drop(1);
            end
            begin
                send(1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0);
                drop(3);
            end
        join
        wait_idle();
        chk("post_rst_grants_left", grant_q.size(), 0);
        grant_chk = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb4_left", exp_q.size(), 0);
        chk("sb15_left", exp15_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
